// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   NOP_INSTR     - instruction presented to decode when nothing is valid
//   FETCH_PC_W    - PC width stored in buffer entries (upper bound for ADDR_WIDTH)
//   fetch_state_t - BOOT / RUN control states
//   fetch_entry_t - one buffered fetch result {pc, instr}
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int unsigned FETCH_PC_W = 32;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_PC_W-1:0] pc;
      logic [31:0]           instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory read bus and decode handshake of the fetch stage.
//   master - the fetch stage (drives requests and the decode payload)
//   slave  - memory/decode side (returns read data and decode ready)
interface fetch_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_rdata;
   logic                  dec_valid;
   logic                  dec_ready;
   logic [31:0]           dec_instr;
   logic [ADDR_WIDTH-1:0] dec_pc;
   logic [ADDR_WIDTH-1:0] dec_pc_plus4;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata,
      output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
      input  dec_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata,
      input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
      output dec_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch_entry_t between instruction memory and decode.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - drop all entries (wins over push/pop)
//   push_i/push_data_i - write one entry at the tail
//   pop_i          - remove the head entry
//   head_o         - registered head entry (valid when count_o != 0)
//   count_o        - number of stored entries, 0..2
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) wr_ptr_d = ~wr_ptr_q;
         if (pop_i)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // The stage only requests when a slot is guaranteed, so these can never fire.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && !pop_i && !flush_i && count_q == 2'd2));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop_i && !flush_i && count_q == 2'd0));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues reads to a synchronous instruction memory and
// delivers {instr, pc, pc+4} to decode. A 2-entry buffer with an empty-buffer
// bypass absorbs decode back-pressure; redirects flush the stage in one cycle.
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   bus (fetch_if.master)  - imem request/address/rdata, decode valid/ready/payload
//   redirect_i, redirect_pc_i - taken branch/jump and its target
//   misaligned_o           - one-cycle pulse when a redirect target is not word aligned
// ADDR_WIDTH must not exceed fetch_pkg::FETCH_PC_W.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   fetch_if.master               bus,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  misaligned_o
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;          // next fetch address
   logic [ADDR_WIDTH-1:0] ifpc_q, ifpc_d;      // address of the read in flight
   logic                  inflight_q, inflight_d;

   fetch_entry_t          head, push_data;
   logic [1:0]            count;
   logic                  buf_push, buf_pop, buf_flush;

   logic                  req, valid, pop, misal;
   logic [ADDR_WIDTH-1:0] addr, dpc, tgt;
   logic [31:0]           instr;
   logic [2:0]            occ;

   assign tgt = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d    = RUN;              // BOOT lasts exactly one cycle after reset
      pc_d       = pc_q;
      ifpc_d     = ifpc_q;
      inflight_d = 1'b0;
      req        = 1'b0;
      addr       = pc_q;
      valid      = 1'b0;
      instr      = NOP_INSTR;
      dpc        = pc_q;
      pop        = 1'b0;
      occ        = 3'd0;
      misal      = 1'b0;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      buf_flush  = 1'b0;
      push_data  = '{pc: FETCH_PC_W'(ifpc_q), instr: bus.imem_rdata};

      case (state_q)
         RUN: begin
            if (redirect_i) begin
               // Drop everything, including this cycle's response, and refetch.
               buf_flush  = 1'b1;
               req        = 1'b1;
               addr       = tgt;
               pc_d       = tgt + PC_STEP;
               ifpc_d     = tgt;
               inflight_d = 1'b1;
               misal      = |redirect_pc_i[1:0];
            end else begin
               if (count != 2'd0) begin
                  valid = 1'b1;
                  instr = head.instr;
                  dpc   = ADDR_WIDTH'(head.pc);
               end else if (inflight_q) begin
                  // Empty buffer: hand the memory response straight to decode.
                  valid = 1'b1;
                  instr = bus.imem_rdata;
                  dpc   = ifpc_q;
               end
               pop      = valid & bus.dec_ready;
               buf_pop  = pop & (count != 2'd0);
               buf_push = inflight_q & ((count != 2'd0) | ~pop);
               // Request only if buffer + in-flight read can still hold its data.
               occ = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
               if (occ < 3'd2) begin
                  req        = 1'b1;
                  pc_d       = pc_q + PC_STEP;
                  ifpc_d     = pc_q;
                  inflight_d = 1'b1;
               end
            end
         end
         default: ;                  // BOOT: no request, redirects ignored
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         ifpc_q     <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ifpc_q     <= ifpc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_buffer u_buf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (buf_flush),
      .push_i      (buf_push),
      .push_data_i (push_data),
      .pop_i       (buf_pop),
      .head_o      (head),
      .count_o     (count)
   );

   assign bus.imem_req     = req;
   assign bus.imem_addr    = addr;
   assign bus.dec_valid    = valid;
   assign bus.dec_instr    = instr;
   assign bus.dec_pc       = dpc;
   assign bus.dec_pc_plus4 = dpc + PC_STEP;
   assign misaligned_o     = misal;

endmodule
